alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered ALU for the next-generation micro datapath. Replaces the combinational 8-bit ALU.
- Adds a start/busy/done handshake and a persistent flag register (C, Z, N, V).
- Adds carry-chained ops (ADC/SBB), arithmetic shift, and a multi-cycle unsigned shift-add multiplier.
- Sits between the register file and the accumulator write-back. The controller sequences it through the handshake.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range is 2 or more.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request. Op and operands are sampled on the cycle it is accepted.
- op  in  4  operation select (encoding below)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  multi-cycle op in progress. Start is ignored while high.
- done  out  1  one-cycle pulse. Result and flags are valid and updated in this cycle.
- result  out  WIDTH  registered result, low half for MUL
- result_hi  out  WIDTH  MUL high half. 0 for all other ops.
- cout  out  1  carry/borrow flag register
- zout  out  1  zero flag register
- nout  out  1  negative flag register (result MSB)
- vout  out  1  signed-overflow flag register

Behaviour:
- Reset (synchronous, rst=1 at the clock edge):
  - busy=0, done=0, result=0, result_hi=0, cout=0, zout=0, nout=0, vout=0, FSM=IDLE.
  - Takes priority over start.
  - rst during MUL aborts it; no done pulse follows.
- Accept rule: start is accepted when start=1 and busy=0. This includes the done cycle, so back-to-back ops are allowed.
- FSM states: IDLE, MUL.
  - IDLE to MUL: accepted start with op=MUL.
  - MUL to IDLE: after WIDTH iterations.
- Timing:
  - Single-cycle ops accepted in cycle T: done=1 in T+1, with result and flags updated.
  - MUL accepted in T: busy=1 in T+1..T+WIDTH, and done=1 with busy=0 in T+WIDTH+1.
  - MUL captures a and b at T. Input changes afterwards have no effect.
- Hold: result, result_hi and flags hold their values between done pulses.
- Op encoding:
  - 0000 ZERO: result=0
  - 0001 NOR: ~(a|b)
  - 0010 PASS: a
  - 0011 SHR: logical a>>1, C=a[0]
  - 0100 SHL: a<<1, C=a[WIDTH-1]
  - 0101 ADD: a+b
  - 0110 SUB: a-b
  - 0111 ADC: a+b+C
  - 1000 SBB: a-b-C
  - 1001 MUL: unsigned a*b
  - 1010 ASR: arithmetic a>>>1, C=a[0]
  - 1011-1111 reserved: behave exactly as ZERO.
- Carry input: ADC and SBB use the cout value registered at the accept cycle.
- Arithmetic is computed at WIDTH+1 bits:
  - ADD/ADC: C = bit WIDTH of the sum.
  - SUB/SBB: C = borrow, i.e. 1 when a < b + Cin unsigned.
- V flag:
  - ADD/ADC: operands have the same sign and the result sign differs.
  - SUB/SBB: operands have different signs and the result sign differs from a.
  - V=0 for all other ops.
- C flag for non-arithmetic ops:
  - ZERO, NOR, PASS, reserved: C=0.
  - MUL: C = (result_hi != 0).
- Z flag: result==0. For MUL, Z is set only when the full 2*WIDTH product is 0.
- N flag: result[WIDTH-1]. For MUL, N = result_hi[WIDTH-1].
- MUL algorithm:
  - Shift-add, one multiplier bit per cycle.
  - Holds a WIDTH+1 accumulator and a WIDTH-bit shifting multiplier.
  - Iteration counter runs 0..WIDTH-1.
- Flags and result change only on done cycles or reset.
- Start while busy is dropped silently. It is not queued.

Test Plan:
- Reset then ADD: assert rst 2 cycles, then start ADD a=0xF0 b=0x20 -> all outputs 0 during reset; next cycle done=1, result=0x10, C=1, Z=0, N=0, V=0.
- Carry chain, back-to-back: ADD 0xFF+0x01 immediately followed by ADC 0x01+0x01 -> first: result=0x00, C=1, Z=1; second: result=0x03, C=0, Z=0. Consecutive done pulses.
- Subtraction and overflow:
  - SUB 0x03-0x05 -> 0xFE, C=1, N=1, V=0.
  - SUB 0x05-0x05 -> 0x00, Z=1, C=0.
  - ADD 0x7F+0x01 -> 0x80, V=1, N=1, C=0.
  - SBB 0x10-0x01 with C=1 -> 0x0E, C=0.
- Shifts and logic:
  - SHR 0x81 -> 0x40, C=1.
  - ASR 0x81 -> 0xC0, C=1.
  - SHL 0x81 -> 0x02, C=1.
  - NOR 0x0F,0xF0 -> 0x00, Z=1.
  - op=1111 -> 0x00, Z=1, C=0.
- Multiply:
  - MUL 0xFF*0xFF at T -> busy=1 for T+1..T+8; start pulses issued meanwhile are ignored; done at T+9 with result_hi=0xFE, result=0x01, C=1, N=1.
  - MUL 0x0F*0x11 -> result_hi=0x00, result=0xFF, C=0.
- Reset mid-MUL and width: rst asserted at T+4 of a MUL -> no done pulse, outputs 0, next start is accepted. Repeat ADD/SUB/MUL checks at WIDTH=16, e.g. MUL 0xFFFF*0x0002 -> result_hi=0x0001, result=0xFFFE, done at T+17.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered ALU with a start/busy/done handshake and a persistent C/Z/N/V
// flag register. Single-cycle ops finish one cycle after they are accepted.
// MUL is an unsigned shift-add multiplier that retires one multiplier bit
// per cycle and takes WIDTH busy cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; wins over start, aborts MUL
//   start      request; op/a/b are sampled when start=1 and busy=0
//   op         operation select (4 bits, see localparams below)
//   a, b       WIDTH-bit operands
//   busy       high while a MUL is iterating; start is ignored then
//   done       one-cycle pulse, result and flags updated in this cycle
//   result     registered result (low half of the product for MUL)
//   result_hi  high half of the product for MUL, 0 for every other op
//   cout       carry/borrow flag
//   zout       zero flag
//   nout       negative flag
//   vout       signed-overflow flag
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             zout,
    output logic             nout,
    output logic             vout
);

    localparam logic [3:0] OP_ZERO = 4'b0000;
    localparam logic [3:0] OP_NOR  = 4'b0001;
    localparam logic [3:0] OP_PASS = 4'b0010;
    localparam logic [3:0] OP_SHR  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_ADC  = 4'b0111;
    localparam logic [3:0] OP_SBB  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_ASR  = 4'b1010;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [0:0]       state;
    logic [CW-1:0]    iter;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mcand;

    logic             accept;
    logic             cin;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] mplier_nxt;

    assign busy   = (state == S_MUL);
    assign accept = start && !busy;

    // Single-cycle datapath. Arithmetic runs at WIDTH+1 bits so the top bit
    // is the carry for adds and the borrow for subtracts (a < b + cin).
    always_comb begin
        cin     = ((op == OP_ADC) || (op == OP_SBB)) ? cout : 1'b0;
        sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        dif_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        case (op)
            OP_NOR:  sc_res = ~(a | b);
            OP_PASS: sc_res = a;
            OP_SHR: begin
                sc_res = {1'b0, a[WIDTH-1:1]};
                sc_c   = a[0];
            end
            OP_SHL: begin
                sc_res = {a[WIDTH-2:0], 1'b0};
                sc_c   = a[WIDTH-1];
            end
            OP_ASR: begin
                sc_res = {a[WIDTH-1], a[WIDTH-1:1]};
                sc_c   = a[0];
            end
            OP_ADD, OP_ADC: begin
                sc_res = sum_ext[WIDTH-1:0];
                sc_c   = sum_ext[WIDTH];
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                sc_res = dif_ext[WIDTH-1:0];
                sc_c   = dif_ext[WIDTH];
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (dif_ext[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                sc_res = '0;
                sc_c   = 1'b0;
                sc_v   = 1'b0;
            end
        endcase
    end

    // One shift-add step. {acc, mplier} is the partial product; the low
    // product bits shift into mplier as the multiplier bits are consumed.
    // acc[WIDTH] is the carry of the add and is always 0 after the shift.
    always_comb begin
        mul_sum    = acc + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_nxt    = {1'b0, mul_sum[WIDTH:1]};
        mplier_nxt = {mul_sum[0], mplier[WIDTH-1:1]};
    end

    // Control FSM and output registers. Outputs only move on a done cycle
    // or reset; a start that arrives while busy is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            iter      <= '0;
            acc       <= '0;
            mplier    <= '0;
            mcand     <= '0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            cout      <= 1'b0;
            zout      <= 1'b0;
            nout      <= 1'b0;
            vout      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state  <= S_MUL;
                            iter   <= '0;
                            acc    <= '0;
                            mplier <= b;
                            mcand  <= a;
                        end else begin
                            done      <= 1'b1;
                            result    <= sc_res;
                            result_hi <= '0;
                            cout      <= sc_c;
                            zout      <= (sc_res == '0);
                            nout      <= sc_res[WIDTH-1];
                            vout      <= sc_v;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mplier <= mplier_nxt;
                    iter   <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        state     <= S_IDLE;
                        iter      <= '0;
                        done      <= 1'b1;
                        result    <= mplier_nxt;
                        result_hi <= acc_nxt[WIDTH-1:0];
                        cout      <= (acc_nxt[WIDTH-1:0] != '0);
                        zout      <= ({acc_nxt[WIDTH-1:0], mplier_nxt} == '0);
                        nout      <= acc_nxt[WIDTH-1];
                        vout      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
